// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types for the stage0 fetch PC sequencer.
//   fsm_state_t : sequencer state encoding (also exported on the debug port)
//   epoch_t     : {eEpoch, wEpoch} tag
//   redirect_t  : one captured flush (valid, source, fence kind, target)
package fetch_redirect_ctrl_pkg;

  // Widest PC the redirect record can hold; the top narrows it back to XLEN.
  localparam int unsigned REDIRECT_PC_W = 64;

  typedef enum logic [1:0] {
    ST_RESET      = 2'd0,
    ST_RUN        = 2'd1,
    ST_FENCE      = 2'd2,
    ST_FENCE_WAIT = 2'd3
  } fsm_state_t;

  typedef logic [1:0] epoch_t;

  typedef struct packed {
    logic                     valid;
    logic                     is_wb;
    logic                     fence;
    logic                     sfence;
    logic [REDIRECT_PC_W-1:0] pc;
  } redirect_t;

endpackage

// File: rtl/fetch_redirect_ctrl_redirect_slot.sv
// Single-entry delayed-redirect register used while a fence is in flight.
// A wb flush always replaces the entry; an ex flush is taken only when the
// entry does not already hold a wb flush.
//   clk_sys, rst_b : clock, async active-low reset
//   capture_en_i   : flushes are being deferred this cycle
//   wb_valid_i     : wb flush this cycle, record in wb_rec_i
//   ex_valid_i     : ex flush this cycle, record in ex_rec_i
//   clear_i        : entry is consumed this cycle
//   merged_o       : entry including this cycle's capture (used on exit)
//   occupied_o     : registered entry is valid
module fetch_redirect_ctrl_redirect_slot
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic      clk_sys,
  input  logic      rst_b,
  input  logic      capture_en_i,
  input  logic      wb_valid_i,
  input  redirect_t wb_rec_i,
  input  logic      ex_valid_i,
  input  redirect_t ex_rec_i,
  input  logic      clear_i,
  output redirect_t merged_o,
  output logic      occupied_o
);

  redirect_t slot_q, slot_d;
  redirect_t merged;

  always_comb begin
    merged = slot_q;
    if (capture_en_i) begin
      if (wb_valid_i) begin
        merged = wb_rec_i;
      end else if (ex_valid_i && !(slot_q.valid && slot_q.is_wb)) begin
        merged = ex_rec_i;
      end
    end
    slot_d = clear_i ? '0 : merged;
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign merged_o   = merged;
  assign occupied_o = slot_q.valid;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Stage0 PC sequencer: picks the next fetch PC (wb flush > ex flush >
// prediction > sequential), owns the epoch bits and sequences fence.i /
// sfence.vma requests, deferring flushes that arrive mid-fence.
//   CLK, RST_N          : clock, async active-low reset
//   wb_flush_*          : write-back redirect (+ fence / sfence qualifiers)
//   ex_flush_*          : execute redirect
//   bpu_*               : prediction for the current fetch_pc
//   fetch_valid/ready   : fetch request handshake, fetch_pc, fetch_epoch
//   fence_req/sfence_req: one-cycle pulses to the memory subsystem
//   fence_done          : memory subsystem fence complete
//   delayed_redirect    : deferred-redirect slot occupied
//   state               : FSM state for debug
//
// state       | meaning
// RESET       | one cycle after reset release, no request
// RUN         | issuing fetch requests
// FENCE       | fence pulse cycle, no request
// FENCE_WAIT  | waiting for fence_done, no request
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 'h1000,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            wb_flush_valid,
  input  logic [XLEN-1:0] wb_flush_pc,
  input  logic            wb_flush_fence,
  input  logic            wb_flush_sfence,
  input  logic            ex_flush_valid,
  input  logic [XLEN-1:0] ex_flush_pc,
  input  logic            bpu_valid,
  input  logic            bpu_taken,
  input  logic [XLEN-1:0] bpu_target,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic [1:0]      fetch_epoch,
  output logic            fence_req,
  output logic            sfence_req,
  input  logic            fence_done,
  output logic            delayed_redirect,
  output logic [1:0]      state
);

  fsm_state_t      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            e_epoch_q, e_epoch_d;
  logic            w_epoch_q, w_epoch_d;
  logic            fence_req_q, fence_req_d;
  logic            sfence_req_q, sfence_req_d;

  logic            fire;
  logic            slot_capture;
  logic            slot_clear;
  logic            slot_occupied;
  redirect_t       wb_rec, ex_rec, slot_merged;

  assign fire = valid_q && fetch_ready;

  always_comb begin
    wb_rec        = '0;
    wb_rec.valid  = 1'b1;
    wb_rec.is_wb  = 1'b1;
    wb_rec.fence  = wb_flush_fence;
    wb_rec.sfence = wb_flush_sfence;
    wb_rec.pc     = REDIRECT_PC_W'(wb_flush_pc);
    ex_rec        = '0;
    ex_rec.valid  = 1'b1;
    ex_rec.pc     = REDIRECT_PC_W'(ex_flush_pc);
  end

  fetch_redirect_ctrl_redirect_slot u_slot (
    .clk_sys      (CLK),
    .rst_b        (RST_N),
    .capture_en_i (slot_capture),
    .wb_valid_i   (wb_flush_valid),
    .wb_rec_i     (wb_rec),
    .ex_valid_i   (ex_flush_valid),
    .ex_rec_i     (ex_rec),
    .clear_i      (slot_clear),
    .merged_o     (slot_merged),
    .occupied_o   (slot_occupied)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    e_epoch_d    = e_epoch_q;
    w_epoch_d    = w_epoch_q;
    fence_req_d  = 1'b0;
    sfence_req_d = 1'b0;
    slot_capture = 1'b0;
    slot_clear   = 1'b0;

    case (state_q)
      ST_RESET: begin
        state_d = ST_RUN;
        valid_d = 1'b1;
      end

      ST_RUN: begin
        if (wb_flush_valid) begin
          w_epoch_d = ~w_epoch_q;
          pc_d      = wb_flush_pc;
          if (wb_flush_fence || wb_flush_sfence) begin
            state_d      = ST_FENCE;
            valid_d      = 1'b0;
            fence_req_d  = wb_flush_fence;
            sfence_req_d = wb_flush_sfence;
          end
        end else if (ex_flush_valid) begin
          e_epoch_d = ~e_epoch_q;
          pc_d      = ex_flush_pc;
        end else if (fire) begin
          pc_d = (bpu_valid && bpu_taken) ? bpu_target : pc_q + XLEN'(PC_STEP);
        end
      end

      ST_FENCE, ST_FENCE_WAIT: begin
        // Epochs move now so in-flight responses are discarded; the PC waits.
        slot_capture = 1'b1;
        if (wb_flush_valid) begin
          w_epoch_d = ~w_epoch_q;
        end else if (ex_flush_valid) begin
          e_epoch_d = ~e_epoch_q;
        end

        if (fence_done) begin
          slot_clear = 1'b1;
          state_d    = ST_RUN;
          valid_d    = 1'b1;
          if (slot_merged.valid) begin
            pc_d = slot_merged.pc[XLEN-1:0];
            if (slot_merged.is_wb && (slot_merged.fence || slot_merged.sfence)) begin
              state_d      = ST_FENCE;
              valid_d      = 1'b0;
              fence_req_d  = slot_merged.fence;
              sfence_req_d = slot_merged.sfence;
            end
          end
        end else if (state_q == ST_FENCE) begin
          state_d = ST_FENCE_WAIT;
        end
      end

      default: begin
        state_d = ST_RESET;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_RESET;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      e_epoch_q    <= 1'b0;
      w_epoch_q    <= 1'b0;
      fence_req_q  <= 1'b0;
      sfence_req_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      e_epoch_q    <= e_epoch_d;
      w_epoch_q    <= w_epoch_d;
      fence_req_q  <= fence_req_d;
      sfence_req_q <= sfence_req_d;
    end
  end

  assign fetch_valid      = valid_q;
  assign fetch_pc         = pc_q;
  assign fetch_epoch      = {e_epoch_q, w_epoch_q};
  assign fence_req        = fence_req_q;
  assign sfence_req       = sfence_req_q;
  assign delayed_redirect = slot_occupied;
  assign state            = state_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
module tb_fetch_redirect_ctrl;

  localparam int M_RESET = 0;
  localparam int M_RUN   = 1;
  localparam int M_FENCE = 2;
  localparam int M_WAIT  = 3;
  localparam logic [63:0] RST_PC = 64'h1000;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        wb_flush_valid = 1'b0;
  logic [63:0] wb_flush_pc = '0;
  logic        wb_flush_fence = 1'b0;
  logic        wb_flush_sfence = 1'b0;
  logic        ex_flush_valid = 1'b0;
  logic [63:0] ex_flush_pc = '0;
  logic        bpu_valid = 1'b0;
  logic        bpu_taken = 1'b0;
  logic [63:0] bpu_target = '0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [63:0] fetch_pc;
  logic [1:0]  fetch_epoch;
  logic        fence_req;
  logic        sfence_req;
  logic        fence_done = 1'b0;
  logic        delayed_redirect;
  logic [1:0]  state;

  fetch_redirect_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .wb_flush_valid(wb_flush_valid), .wb_flush_pc(wb_flush_pc),
    .wb_flush_fence(wb_flush_fence), .wb_flush_sfence(wb_flush_sfence),
    .ex_flush_valid(ex_flush_valid), .ex_flush_pc(ex_flush_pc),
    .bpu_valid(bpu_valid), .bpu_taken(bpu_taken), .bpu_target(bpu_target),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_epoch(fetch_epoch),
    .fence_req(fence_req), .sfence_req(sfence_req), .fence_done(fence_done),
    .delayed_redirect(delayed_redirect), .state(state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] st;
    logic       v;
    logic       dr;
    logic       f;
    logic       s;
    logic [1:0] ep;
  } cyc_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [1:0]  ep;
  } fire_t;

  cyc_t  cyc_q[$];
  fire_t fire_q[$];

  // Reference model: mode, current request PC, epochs, pending redirect.
  int          m_mode;
  logic [63:0] m_pc;
  logic        m_e, m_w, m_kf, m_ks;
  logic        p_has, p_wb, p_f, p_s;
  logic [63:0] p_pc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RESET; m_pc = RST_PC; m_e = 0; m_w = 0; m_kf = 0; m_ks = 0;
    p_has = 0; p_wb = 0; p_f = 0; p_s = 0; p_pc = '0;
  endtask

  task automatic start_fence(input logic f, input logic s);
    m_mode = M_FENCE; m_kf = f; m_ks = s;
  endtask

  task automatic model_step();
    case (m_mode)
      M_RESET: m_mode = M_RUN;
      M_RUN: begin
        if (wb_flush_valid) begin
          m_w = ~m_w; m_pc = wb_flush_pc;
          if (wb_flush_fence || wb_flush_sfence) start_fence(wb_flush_fence, wb_flush_sfence);
        end else if (ex_flush_valid) begin
          m_e = ~m_e; m_pc = ex_flush_pc;
        end else if (fetch_ready) begin
          m_pc = (bpu_valid && bpu_taken) ? bpu_target : m_pc + 64'd4;
        end
      end
      default: begin
        if (wb_flush_valid) begin
          m_w = ~m_w;
          p_has = 1; p_wb = 1; p_f = wb_flush_fence; p_s = wb_flush_sfence; p_pc = wb_flush_pc;
        end else if (ex_flush_valid) begin
          m_e = ~m_e;
          if (!(p_has && p_wb)) begin
            p_has = 1; p_wb = 0; p_f = 0; p_s = 0; p_pc = ex_flush_pc;
          end
        end
        if (fence_done) begin
          m_mode = M_RUN;
          if (p_has) begin
            m_pc = p_pc;
            if (p_wb && (p_f || p_s)) start_fence(p_f, p_s);
            p_has = 0;
          end
        end else if (m_mode == M_FENCE) begin
          m_mode = M_WAIT;
        end
      end
    endcase
  endtask

  // Record what the current cycle should show, let the clock edge happen,
  // then advance the model with the inputs that were presented.
  task automatic tick();
    cyc_t c;
    c.st = 2'(m_mode);
    c.v  = (m_mode == M_RUN);
    c.dr = p_has;
    c.f  = (m_mode == M_FENCE) && m_kf;
    c.s  = (m_mode == M_FENCE) && m_ks;
    c.ep = {m_e, m_w};
    cyc_q.push_back(c);
    if (m_mode == M_RUN && fetch_ready) fire_q.push_back({m_pc, m_e, m_w});
    @(posedge CLK);
    if (!RST_N) model_reset();
    else model_step();
    #1;
  endtask

  task automatic quiet();
    wb_flush_valid = 0; wb_flush_fence = 0; wb_flush_sfence = 0;
    ex_flush_valid = 0; bpu_valid = 0; bpu_taken = 0; fence_done = 0;
  endtask

  task automatic rand_inputs();
    fetch_ready     = ($urandom_range(0, 9) < 7);
    wb_flush_valid  = ($urandom_range(0, 19) == 0);
    wb_flush_pc     = {$urandom, $urandom} & ~64'h3;
    wb_flush_fence  = ($urandom_range(0, 2) == 0);
    wb_flush_sfence = ($urandom_range(0, 3) == 0);
    ex_flush_valid  = ($urandom_range(0, 9) == 0);
    ex_flush_pc     = {$urandom, $urandom} & ~64'h3;
    bpu_valid       = $urandom_range(0, 1);
    bpu_taken       = $urandom_range(0, 1);
    bpu_target      = {$urandom, $urandom} & ~64'h3;
    fence_done      = ($urandom_range(0, 3) == 0);
  endtask

  // Monitor: per-cycle status plus every fired request against the queues.
  always @(negedge CLK) begin
    cyc_t  c;
    fire_t f;
    if (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      chk("state", 64'(state), 64'(c.st));
      chk("fetch_valid", 64'(fetch_valid), 64'(c.v));
      chk("delayed_redirect", 64'(delayed_redirect), 64'(c.dr));
      chk("fence_req", 64'(fence_req), 64'(c.f));
      chk("sfence_req", 64'(sfence_req), 64'(c.s));
      chk("fetch_epoch", 64'(fetch_epoch), 64'(c.ep));
    end
    if (fetch_valid === 1'b1 && fetch_ready === 1'b1) begin
      if (fire_q.size() == 0) begin
        chk("unexpected_fire_pc", fetch_pc, 64'hx);
      end else begin
        f = fire_q.pop_front();
        chk("fire_pc", fetch_pc, f.pc);
        chk("fire_epoch", 64'(fetch_epoch), 64'(f.ep));
      end
    end
  end

  initial begin
    model_reset();
    quiet();
    @(posedge CLK); #1;
    repeat (3) tick();
    RST_N = 1;

    // Sequential fetch from reset PC, then a taken prediction, then stalls.
    fetch_ready = 1;
    repeat (3) tick();
    bpu_valid = 1; bpu_taken = 1; bpu_target = 64'h2000;
    tick();
    quiet(); fetch_ready = 0;
    bpu_valid = 1; bpu_taken = 1; bpu_target = 64'hdead0;
    repeat (3) tick();
    quiet();

    // wb and ex flush together: wb wins, eEpoch untouched.
    fetch_ready = 1;
    wb_flush_valid = 1; wb_flush_pc = 64'h3000;
    ex_flush_valid = 1; ex_flush_pc = 64'h4000;
    tick();
    quiet();
    tick();

    // fence.i with a 10-cycle completion.
    wb_flush_valid = 1; wb_flush_pc = 64'h5000; wb_flush_fence = 1;
    tick();
    quiet();
    repeat (10) tick();
    fence_done = 1; tick(); quiet();
    repeat (2) tick();

    // Flushes deferred during FENCE_WAIT; later wb replaces pending ex.
    wb_flush_valid = 1; wb_flush_pc = 64'h5100; wb_flush_sfence = 1;
    tick(); quiet();
    repeat (2) tick();
    ex_flush_valid = 1; ex_flush_pc = 64'h6000; tick(); quiet();
    wb_flush_valid = 1; wb_flush_pc = 64'h7000; tick(); quiet();
    repeat (2) tick();
    fence_done = 1; tick(); quiet();
    repeat (2) tick();

    // Sequential wrap at the top of the address space.
    ex_flush_valid = 1; ex_flush_pc = 64'hFFFF_FFFF_FFFF_FFFC; tick(); quiet();
    repeat (2) tick();

    // Async reset while waiting on a fence.
    wb_flush_valid = 1; wb_flush_pc = 64'h8000; wb_flush_fence = 1; wb_flush_sfence = 1;
    tick(); quiet();
    repeat (2) tick();
    RST_N = 0;
    #1;
    chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("rst_fetch_pc", fetch_pc, RST_PC);
    chk("rst_epoch", 64'(fetch_epoch), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_fence_req", 64'({fence_req, sfence_req}), 64'd0);
    chk("rst_delayed", 64'(delayed_redirect), 64'd0);
    model_reset();
    fence_done = 1;
    repeat (2) tick();
    RST_N = 1;
    repeat (4) tick();
    quiet();
    repeat (2) tick();

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end
    quiet(); fence_done = 1;
    repeat (4) tick();

    chk("fire_queue_drained", 64'(fire_q.size()), 64'd0);
    chk("cycle_queue_drained", 64'(cyc_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Stage0 PC sequencer for the chromite fetch front end.
- Arbitrates the next-fetch PC between write-back flush, execute flush, BPU prediction and sequential increment.
- Owns the eEpoch/wEpoch registers and sequences fence/sfence requests to the instruction memory subsystem.
- Holds a single delayed-redirect slot for flushes that arrive while a fence is in progress.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 'h1000, PC loaded on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- wb_flush_valid  in  1  write-back redirect request
- wb_flush_pc  in  XLEN  write-back redirect target
- wb_flush_fence  in  1  redirect caused by fence.i (qualified by wb_flush_valid)
- wb_flush_sfence  in  1  redirect caused by sfence.vma (qualified by wb_flush_valid)
- ex_flush_valid  in  1  execute misprediction redirect
- ex_flush_pc  in  XLEN  execute redirect target
- bpu_valid  in  1  prediction valid for current fetch_pc
- bpu_taken  in  1  prediction taken
- bpu_target  in  XLEN  predicted target
- fetch_valid  out  1  fetch request valid
- fetch_ready  in  1  fetch request accepted
- fetch_pc  out  XLEN  fetch address
- fetch_epoch  out  2  {eEpoch, wEpoch} tag for the request
- fence_req  out  1  single-cycle fence.i pulse
- sfence_req  out  1  single-cycle sfence pulse
- fence_done  in  1  memory subsystem fence complete
- delayed_redirect  out  1  pending-redirect slot occupied
- state  out  2  FSM state, for debug and coverage

Behaviour:
- Reset values: fetch_pc=RESET_PC, fetch_valid=0, epochs=2'b00, fence_req=0, sfence_req=0, delayed_redirect=0, state=RESET.
- FSM states: RESET(0), RUN(1), FENCE(2), FENCE_WAIT(3).
- RESET: one cycle after reset release, go to RUN and assert fetch_valid. The first request is at RESET_PC.
- RUN, fetch handshake: a request fires when fetch_valid && fetch_ready.
  - On fire with bpu_valid && bpu_taken: fetch_pc <= bpu_target.
  - On fire otherwise: fetch_pc <= fetch_pc + PC_STEP, modulo 2^XLEN (wraps silently).
- RUN, stability: with no fire and no flush, fetch_pc and fetch_valid hold. Only a flush may change an unfired request.
- Flush priority: wb > ex > bpu > sequential.
  - wb flush (no fence/sfence): wEpoch toggles; fetch_pc <= wb_flush_pc next cycle; fetch_valid stays 1. Any ex flush in the same cycle is dropped and eEpoch is unchanged.
  - ex flush alone: eEpoch toggles; fetch_pc <= ex_flush_pc next cycle.
  - A flush in the same cycle as a fire overrides the increment/prediction.
- fetch_epoch is combinational from the epoch registers, so a redirected request carries the new epoch.
- Fence sequence (wb flush with fence or sfence):
  - wEpoch toggles and fetch_pc <= wb_flush_pc.
  - Next cycle: state=FENCE, fetch_valid=0, fence_req and/or sfence_req pulse high for exactly one cycle; both pulse if both are set.
  - Then go to FENCE_WAIT and wait for fence_done; fetch_valid stays 0.
  - On fence_done: go to RUN; fetch_valid=1 next cycle with the stored PC.
  - fence_done in FENCE (same cycle as the pulse) is legal and goes directly to RUN.
- Flush while in FENCE or FENCE_WAIT:
  - The flush is captured in the delayed slot and delayed_redirect=1; the epoch toggles immediately.
  - A later wb flush overwrites a pending ex flush. A later ex flush does not overwrite a pending wb flush.
  - On exit to RUN, the pending PC is used and delayed_redirect clears.
  - A pending wb flush with fence set re-enters FENCE rather than RUN.
- bpu inputs are ignored unless a fire occurs in RUN.
- Reset asserted mid-fence: everything returns to reset values immediately (asynchronous). fence_done arriving after reset is ignored in RESET/RUN.
- No combinational path from fetch_ready to fetch_valid.

Decomposition:
- Shared package holds:
  - the fsm_state_t enum (RESET/RUN/FENCE/FENCE_WAIT);
  - the redirect_t struct {valid, is_wb, fence, sfence, pc};
  - the epoch_t typedef (2 bits).
- One sub-module: redirect_slot, the delayed-redirect register with the wb-over-ex overwrite rule.

Test Plan:
- Reset release, fetch_ready=1, no predictions -> fetch_pc 0x1000, 0x1004, 0x1008 on consecutive cycles; epoch 00.
- At a fire on 0x1008, bpu_valid=1, bpu_taken=1, target 0x2000 -> next fetch_pc 0x2000; with fetch_ready=0 for 3 cycles, pc holds at 0x2000.
- wb_flush 0x3000 and ex_flush 0x4000 in the same cycle -> next fetch_pc 0x3000, fetch_epoch 01, eEpoch unchanged.
- wb_flush 0x5000 with fence=1 -> fetch_valid=0, one-cycle fence_req, state FENCE then FENCE_WAIT; fence_done after 10 cycles -> fetch_pc 0x5000 with fetch_valid=1 the next cycle.
- During FENCE_WAIT, ex_flush 0x6000 then wb_flush 0x7000 -> delayed_redirect=1 and the final epoch reflects both toggles; after fence_done, fetch_pc 0x7000 and delayed_redirect=0.
- RST_N low while in FENCE_WAIT -> all outputs return to reset values immediately; fetch restarts at 0x1000.
